// File: rtl/cpu_control.sv
// cpu_control: multicycle control FSM for the 16-bit CPU.
// Consumes opcode, immediate bit and N/Z flags from the datapath and drives every datapath
// strobe plus the memory enables. Outputs depend only on (state, i_instr, i_imm).
`timescale 1ns / 1ps

module cpu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_instr,
  input  logic       i_imm,
  input  logic       i_N,
  input  logic       i_Z,
  output logic       o_PC_write,
  output logic       o_Addr_sel,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_MDR_load,
  output logic       o_IR_load,
  output logic       o_OpA_sel,
  output logic       o_OpAB_load,
  output logic [1:0] o_ALU_1_sel,
  output logic [1:0] o_ALU_2_sel,
  output logic [1:0] o_ALUop_sel,
  output logic       o_ALU_out,
  output logic       o_RF_write,
  output logic       o_Reg_in,
  output logic       o_Flag_write,
  output logic       o_RF_write_call,
  output logic       o_mov_hi,
  output logic       o_halted
);

  localparam logic [3:0] OpMv   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpCmp  = 4'b0011;
  localparam logic [3:0] OpLd   = 4'b0100;
  localparam logic [3:0] OpSt   = 4'b0101;
  localparam logic [3:0] OpMvhi = 4'b0110;
  localparam logic [3:0] OpJ    = 4'b1000;
  localparam logic [3:0] OpJz   = 4'b1001;
  localparam logic [3:0] OpJn   = 4'b1010;
  localparam logic [3:0] OpCall = 4'b1100;

  // ALU input/operation encodings
  localparam logic [1:0] Alu1Pc    = 2'b00;
  localparam logic [1:0] Alu1OpA   = 2'b01;
  localparam logic [1:0] Alu1Zero  = 2'b11;
  localparam logic [1:0] Alu2OpB   = 2'b00;
  localparam logic [1:0] Alu2Two   = 2'b01;
  localparam logic [1:0] Alu2Imm8  = 2'b10;
  localparam logic [1:0] Alu2Imm11 = 2'b11;
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluSub    = 2'b01;
  localparam logic [1:0] AluPassA  = 2'b10;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StFetch2,
    StDecode,
    StExecAlu,
    StExecMv,
    StExecMvhi,
    StWb,
    StExecLd,
    StLdWait,
    StLdWb,
    StExecSt,
    StJump,
    StCallLink,
    StCallJump,
    StHalt
  } state_e;

  state_e state_q, state_d;

  // State register; reset forces RESET immediately so every strobe drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  state_d = StFetch2;
      StFetch2: state_d = StDecode;
      StDecode: begin
        case (i_instr)
          OpAdd, OpSub, OpCmp: state_d = StExecAlu;
          OpMv:                state_d = StExecMv;
          OpMvhi:              state_d = StExecMvhi;
          OpLd:                state_d = StExecLd;
          OpSt:                state_d = StExecSt;
          OpJ:                 state_d = StJump;
          OpJz:                state_d = i_Z ? StJump : StFetch;
          OpJn:                state_d = i_N ? StJump : StFetch;
          OpCall:              state_d = StCallLink;
          default:             state_d = StHalt;
        endcase
      end
      StExecAlu:  state_d = (i_instr == OpCmp) ? StFetch : StWb;
      StExecMv:   state_d = StWb;
      StExecMvhi: state_d = StWb;
      StWb:       state_d = StFetch;
      StExecLd:   state_d = StLdWait;
      StLdWait:   state_d = StLdWb;
      StLdWb:     state_d = StFetch;
      StExecSt:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StCallLink: state_d = StCallJump;
      StCallJump: state_d = StFetch;
      StHalt:     state_d = StHalt;
    endcase
  end

  // Strobe decode per state.
  always_comb begin
    o_PC_write      = 1'b0;
    o_Addr_sel      = 1'b1;
    o_mem_rd        = 1'b0;
    o_mem_wr        = 1'b0;
    o_MDR_load      = 1'b0;
    o_IR_load       = 1'b0;
    o_OpA_sel       = 1'b0;
    o_OpAB_load     = 1'b0;
    o_ALU_1_sel     = Alu1Pc;
    o_ALU_2_sel     = Alu2OpB;
    o_ALUop_sel     = AluAdd;
    o_ALU_out       = 1'b0;
    o_RF_write      = 1'b0;
    o_Reg_in        = 1'b0;
    o_Flag_write    = 1'b0;
    o_RF_write_call = 1'b0;
    o_mov_hi        = 1'b0;
    o_halted        = 1'b0;
    unique case (state_q)
      StReset: o_Addr_sel = 1'b0;
      StFetch: begin
        o_mem_rd    = 1'b1;
        o_ALU_1_sel = Alu1Pc;
        o_ALU_2_sel = Alu2Two;
        o_ALUop_sel = AluAdd;
        o_PC_write  = 1'b1;
      end
      StFetch2: o_IR_load = 1'b1;
      StDecode: o_OpAB_load = 1'b1;
      StExecAlu: begin
        o_ALU_1_sel  = Alu1OpA;
        o_ALU_2_sel  = i_imm ? Alu2Imm8 : Alu2OpB;
        o_ALUop_sel  = (i_instr == OpAdd) ? AluAdd : AluSub;
        o_ALU_out    = 1'b1;
        o_Flag_write = 1'b1;
      end
      StExecMv: begin
        o_ALU_1_sel = Alu1Zero;
        o_ALU_2_sel = i_imm ? Alu2Imm8 : Alu2OpB;
        o_ALUop_sel = AluAdd;
        o_ALU_out   = 1'b1;
      end
      StExecMvhi: begin
        o_ALU_out = 1'b1;
        o_mov_hi  = 1'b1;
      end
      StWb: o_RF_write = 1'b1;
      StExecLd: begin
        o_Addr_sel = 1'b0;
        o_mem_rd   = 1'b1;
      end
      StLdWait: o_MDR_load = 1'b1;
      StLdWb: begin
        o_RF_write = 1'b1;
        o_Reg_in   = 1'b1;
      end
      StExecSt: begin
        o_Addr_sel = 1'b0;
        o_mem_wr   = 1'b1;
      end
      StJump, StCallJump: begin
        o_PC_write = 1'b1;
        if (i_imm) begin
          o_ALU_1_sel = Alu1Pc;
          o_ALU_2_sel = Alu2Imm11;
          o_ALUop_sel = AluAdd;
        end else begin
          o_ALU_1_sel = Alu1OpA;
          o_ALUop_sel = AluPassA;
        end
        // R7 takes the link latched in CALL_LINK; opA was captured in DECODE, so callr r7
        // still jumps to the old R7.
        if (state_q == StCallJump) begin
          o_RF_write      = 1'b1;
          o_RF_write_call = 1'b1;
        end
      end
      StCallLink: begin
        o_ALU_1_sel = Alu1Pc;
        o_ALUop_sel = AluPassA;
        o_ALU_out   = 1'b1;
      end
      StHalt: begin
        o_Addr_sel = 1'b0;
        o_halted   = 1'b1;
      end
    endcase
  end

endmodule
